// File: rtl/ula_multiciclo_if.sv
// Request/result bundle between the control unit (master) and the multi-cycle ALU (slave).
// inicio is honoured only while ocupado=0; pronto pulses once per accepted operation.
interface ula_multiciclo_if #(
  parameter int LARGURA = 32
);
  logic               inicio;
  logic [3:0]         operacao;
  logic [LARGURA-1:0] dado1;
  logic [LARGURA-1:0] dado2;
  logic [LARGURA-1:0] saida;
  logic [LARGURA-1:0] saida_alta;
  logic               igual;
  logic               div_zero;
  logic               ocupado;
  logic               pronto;

  modport master (
    output inicio, operacao, dado1, dado2,
    input  saida, saida_alta, igual, div_zero, ocupado, pronto
  );

  modport slave (
    input  inicio, operacao, dado1, dado2,
    output saida, saida_alta, igual, div_zero, ocupado, pronto
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Registered ALU: single-cycle ops valid 1 cycle after accept, mulu/divu after LARGURA cycles.
// No queueing: inicio is ignored while ocupado=1; the control unit must stall on pronto.
module ula_multiciclo #(
  parameter int LARGURA = 32,
  parameter int SHAMT   = $clog2(LARGURA)
) (
  input  logic            clock,
  input  logic            reset,
  ula_multiciclo_if.slave bus
);

  localparam int CW = $clog2(LARGURA) + 1;

  typedef enum logic [0:0] {OCIOSO, CALCULA} estado_t;

  estado_t            estado, estado_nxt;
  logic [CW-1:0]      contador, contador_nxt;
  logic               eh_div, eh_div_nxt;
  logic [LARGURA-1:0] alto, alto_nxt;
  logic [LARGURA-1:0] baixo, baixo_nxt;
  logic [LARGURA-1:0] operando, operando_nxt;
  logic [LARGURA-1:0] saida_q, saida_nxt;
  logic [LARGURA-1:0] alta_q, alta_nxt;
  logic               igual_q, igual_nxt;
  logic               dz_q, dz_nxt;
  logic               pronto_q, pronto_nxt;

  logic [LARGURA-1:0] simples;
  logic               igual_simples;
  logic [SHAMT-1:0]   desloc;
  logic               iterativa;

  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   resto_desl;
  logic [LARGURA:0]   dif;
  logic [LARGURA-1:0] passo_alto;
  logic [LARGURA-1:0] passo_baixo;

  assign desloc    = bus.dado2[SHAMT-1:0];
  assign iterativa = (bus.operacao == 4'b1101) || (bus.operacao == 4'b1110);

  always_comb begin
    simples       = '0;
    igual_simples = 1'b0;
    case (bus.operacao)
      4'b0000: simples = bus.dado1 + bus.dado2;
      4'b0001: simples = bus.dado1 - bus.dado2;
      4'b0010: simples = bus.dado1 & bus.dado2;
      4'b0011: simples = bus.dado1 | bus.dado2;
      4'b0100: simples = {bus.dado1[LARGURA-2:0], 1'b0};
      4'b0101: simples = {1'b0, bus.dado1[LARGURA-1:1]};
      4'b0110: igual_simples = (bus.dado1 == bus.dado2);
      4'b0111: igual_simples = (bus.dado1 != bus.dado2);
      4'b1000: simples = {{(LARGURA-1){1'b0}}, (bus.dado1 < bus.dado2)};
      4'b1001: simples = ~bus.dado1;
      4'b1010: simples = bus.dado1 << desloc;
      4'b1011: simples = bus.dado1 >> desloc;
      4'b1100: simples = LARGURA'($signed(bus.dado1) >>> desloc);
      default: simples = '0;
    endcase
  end

  // One iteration step. alto/baixo hold partial product or remainder/quotient;
  // operando holds multiplicand or divisor. A zero divisor never borrows, so the
  // quotient fills with ones and the remainder collects the dividend unaided.
  always_comb begin
    soma       = {1'b0, alto} + {1'b0, (baixo[0] ? operando : {LARGURA{1'b0}})};
    resto_desl = {alto, baixo[LARGURA-1]};
    dif        = resto_desl - {1'b0, operando};
    if (eh_div) begin
      if (!dif[LARGURA]) begin
        passo_alto  = dif[LARGURA-1:0];
        passo_baixo = {baixo[LARGURA-2:0], 1'b1};
      end else begin
        passo_alto  = resto_desl[LARGURA-1:0];
        passo_baixo = {baixo[LARGURA-2:0], 1'b0};
      end
    end else begin
      {passo_alto, passo_baixo} = {soma, baixo[LARGURA-1:1]};
    end
  end

  always_comb begin
    estado_nxt   = estado;
    contador_nxt = contador;
    eh_div_nxt   = eh_div;
    alto_nxt     = alto;
    baixo_nxt    = baixo;
    operando_nxt = operando;
    saida_nxt    = saida_q;
    alta_nxt     = alta_q;
    igual_nxt    = igual_q;
    dz_nxt       = dz_q;
    pronto_nxt   = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          if (iterativa) begin
            estado_nxt   = CALCULA;
            contador_nxt = CW'(LARGURA);
            eh_div_nxt   = (bus.operacao == 4'b1110);
            alto_nxt     = '0;
            baixo_nxt    = bus.dado1;
            operando_nxt = bus.dado2;
          end else begin
            saida_nxt  = simples;
            alta_nxt   = '0;
            igual_nxt  = igual_simples;
            dz_nxt     = 1'b0;
            pronto_nxt = 1'b1;
          end
        end
      end
      CALCULA: begin
        alto_nxt     = passo_alto;
        baixo_nxt    = passo_baixo;
        contador_nxt = contador - CW'(1);
        if (contador == CW'(1)) begin
          estado_nxt = OCIOSO;
          saida_nxt  = passo_baixo;
          alta_nxt   = passo_alto;
          igual_nxt  = 1'b0;
          dz_nxt     = eh_div && (operando == '0);
          pronto_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      contador <= '0;
      eh_div   <= 1'b0;
      alto     <= '0;
      baixo    <= '0;
      operando <= '0;
      saida_q  <= '0;
      alta_q   <= '0;
      igual_q  <= 1'b0;
      dz_q     <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado   <= estado_nxt;
      contador <= contador_nxt;
      eh_div   <= eh_div_nxt;
      alto     <= alto_nxt;
      baixo    <= baixo_nxt;
      operando <= operando_nxt;
      saida_q  <= saida_nxt;
      alta_q   <= alta_nxt;
      igual_q  <= igual_nxt;
      dz_q     <= dz_nxt;
      pronto_q <= pronto_nxt;
    end
  end

  assign bus.saida      = saida_q;
  assign bus.saida_alta = alta_q;
  assign bus.igual      = igual_q;
  assign bus.div_zero   = dz_q;
  assign bus.pronto     = pronto_q;
  assign bus.ocupado    = (estado == CALCULA);

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomised self-checking bench for ula_multiciclo against an arithmetic reference model.
module tb_ula_multiciclo;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ncic  = 0;
  int   t_acc = 0;

  ula_multiciclo_if #(.LARGURA(W)) bus ();
  ula_multiciclo #(.LARGURA(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) ncic++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic modelo(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic [W-1:0] h,
                        output logic ig, output logic dz);
    logic [2*W-1:0] p;
    int n;
    s = '0; h = '0; ig = 1'b0; dz = 1'b0;
    n = int'(b[4:0]);
    case (op)
      4'd0:  s = a + b;
      4'd1:  s = a - b;
      4'd2:  s = a & b;
      4'd3:  s = a | b;
      4'd4:  s = a << 1;
      4'd5:  s = a >> 1;
      4'd6:  ig = (a == b);
      4'd7:  ig = (a != b);
      4'd8:  s = (a < b) ? 32'd1 : 32'd0;
      4'd9:  s = ~a;
      4'd10: s = a << n;
      4'd11: s = a >> n;
      4'd12: s = (a >> n) | (a[W-1] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
      4'd13: begin p = 64'(a) * 64'(b); s = p[W-1:0]; h = p[2*W-1:W]; end
      4'd14: begin
        if (b == 0) begin s = '1; h = a; dz = 1'b1; end
        else begin s = a / b; h = a % b; end
      end
      default: s = '0;
    endcase
  endtask

  // Issues one operation from idle and waits (bounded) for its pronto; lat=-1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int ocup);
    @(negedge clock);
    bus.inicio = 1'b1; bus.operacao = op; bus.dado1 = a; bus.dado2 = b;
    @(posedge clock); #1;
    t_acc = ncic;
    bus.inicio = 1'b0; bus.operacao = 4'($urandom); bus.dado1 = $urandom; bus.dado2 = $urandom;
    lat = -1; ocup = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.ocupado) ocup++;
      if (bus.pronto) begin lat = ncic - t_acc; break; end
    end
  endtask

  function automatic logic [3:0] op_simples();
    int r;
    r = $urandom_range(0, 13);
    return (r == 13) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_reset();
    int np;
    bus.inicio = 1'b0; bus.operacao = '0; bus.dado1 = '0; bus.dado2 = '0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({bus.saida, bus.saida_alta, bus.igual, bus.div_zero, bus.ocupado, bus.pronto} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h/%h ig=%b dz=%b oc=%b pr=%b exp all 0",
               bus.saida, bus.saida_alta, bus.igual, bus.div_zero, bus.ocupado, bus.pronto);
    end
    np = 0;
    repeat (5) begin @(negedge clock); if (bus.pronto) np++; end
    tests++;
    if (np !== 0) begin fails++; $display("FAIL reset_idle_pronto got %0d exp 0", np); end
  endtask

  task automatic test_single();
    logic [3:0]   ops [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
    logic [W-1:0] as  [4] = '{32'h7FFF_FFFF, 32'h0, 32'd5, 32'd5};
    logic [W-1:0] bs  [4] = '{32'h1, 32'h1, 32'd5, 32'd5};
    logic [W-1:0] es  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic         eig [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [97:0]  got, expv;
    logic [W-1:0] s, h, a, b;
    logic ig, dz;
    logic [3:0] op;
    int lat, oc;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, oc);
      got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
      expv = {es[i], 32'h0, eig[i], 1'b0, 32'd0};
      tests++;
      if (got !== expv) begin fails++; $display("FAIL single_dir op=%h got %h exp %h", ops[i], got, expv); end
    end
    for (int i = 0; i < 40; i++) begin
      op = op_simples(); a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      modelo(op, a, b, s, h, ig, dz);
      run_op(op, a, b, lat, oc);
      got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
      expv = {s, h, ig, dz, 32'd0};
      tests++;
      if (got !== expv) begin fails++; $display("FAIL single_rnd op=%h a=%h b=%h got %h exp %h", op, a, b, got, expv); end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]   ops [3] = '{4'd12, 4'd11, 4'd10};
    logic [W-1:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h1};
    logic [W-1:0] bs  [3] = '{32'h24, 32'h24, 32'd31};
    logic [W-1:0] es  [3] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000};
    logic [97:0] got, expv;
    int lat, oc;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], as[i], bs[i], lat, oc);
      got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
      expv = {es[i], 32'h0, 1'b0, 1'b0, 32'd0};
      tests++;
      if (got !== expv) begin fails++; $display("FAIL shift op=%h got %h exp %h", ops[i], got, expv); end
    end
  endtask

  task automatic test_mulu();
    logic [97:0] got, expv;
    logic [W-1:0] s, h, a, b;
    logic ig, dz;
    int lat, oc;
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, oc);
    got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
    expv = {32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd32};
    tests++;
    if (got !== expv) begin fails++; $display("FAIL mulu_max got %h exp %h", got, expv); end
    tests++;
    if (oc !== 32) begin fails++; $display("FAIL mulu_ocupado_cycles got %0d exp 32", oc); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = (i == 0) ? 32'h0 : $urandom;
      modelo(4'd13, a, b, s, h, ig, dz);
      run_op(4'd13, a, b, lat, oc);
      got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
      expv = {s, h, 1'b0, 1'b0, 32'd32};
      tests++;
      if (got !== expv) begin fails++; $display("FAIL mulu_rnd a=%h b=%h got %h exp %h", a, b, got, expv); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] s, h, a, b;
    logic ig, dz;
    logic [97:0] got, expv;
    int lat, np;
    a = $urandom; b = $urandom;
    modelo(4'd13, a, b, s, h, ig, dz);
    @(negedge clock);
    bus.inicio = 1'b1; bus.operacao = 4'd13; bus.dado1 = a; bus.dado2 = b;
    @(posedge clock); #1;
    t_acc = ncic; bus.inicio = 1'b0;
    repeat (4) @(negedge clock);
    bus.inicio = 1'b1; bus.operacao = 4'd0; bus.dado1 = 32'd3; bus.dado2 = 32'd4;
    @(negedge clock);
    bus.inicio = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.pronto) begin lat = ncic - t_acc; break; end
    end
    got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
    expv = {s, h, 1'b0, 1'b0, 32'd32};
    tests++;
    if (got !== expv) begin fails++; $display("FAIL busy_ignore got %h exp %h", got, expv); end
    np = 0;
    repeat (5) begin @(negedge clock); if (bus.pronto) np++; end
    tests++;
    if ({np, bus.saida, bus.saida_alta} !== {32'd0, s, h}) begin
      fails++; $display("FAIL busy_hold pronto_count=%0d saida=%h alta=%h exp 0 %h %h", np, bus.saida, bus.saida_alta, s, h);
    end
  endtask

  task automatic test_divu();
    logic [97:0] got, expv;
    logic [W-1:0] s, h, a, b;
    logic ig, dz;
    int lat, oc;
    run_op(4'd14, 32'd100, 32'd7, lat, oc);
    got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
    expv = {32'd14, 32'd2, 1'b0, 1'b0, 32'd32};
    tests++;
    if (got !== expv) begin fails++; $display("FAIL divu_100_7 got %h exp %h", got, expv); end
    run_op(4'd14, 32'd100, 32'd0, lat, oc);
    got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
    expv = {32'hFFFF_FFFF, 32'd100, 1'b0, 1'b1, 32'd32};
    tests++;
    if (got !== expv) begin fails++; $display("FAIL divu_by_zero got %h exp %h", got, expv); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) b = a;
      modelo(4'd14, a, b, s, h, ig, dz);
      run_op(4'd14, a, b, lat, oc);
      got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 32'(lat)};
      expv = {s, h, 1'b0, dz, 32'd32};
      tests++;
      if (got !== expv) begin fails++; $display("FAIL divu_rnd a=%h b=%h got %h exp %h", a, b, got, expv); end
    end
  endtask

  task automatic test_reset_mid();
    int np;
    @(negedge clock);
    bus.inicio = 1'b1; bus.operacao = 4'd13; bus.dado1 = $urandom; bus.dado2 = $urandom;
    @(posedge clock); #1;
    bus.inicio = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.inicio = 1'b1; bus.operacao = 4'd0;
    @(posedge clock); #1;
    reset = 1'b1; bus.inicio = 1'b0;
    @(negedge clock);
    tests++;
    if ({bus.saida, bus.saida_alta, bus.igual, bus.div_zero, bus.ocupado, bus.pronto} !== '0) begin
      fails++;
      $display("FAIL reset_mid got %h/%h ig=%b dz=%b oc=%b pr=%b exp all 0",
               bus.saida, bus.saida_alta, bus.igual, bus.div_zero, bus.ocupado, bus.pronto);
    end
    np = 0;
    repeat (40) begin @(negedge clock); if (bus.pronto) np++; end
    tests++;
    if (np !== 0) begin fails++; $display("FAIL reset_mid_pronto got %0d exp 0", np); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, s, h;
    logic [3:0]   op;
    logic ig, dz;
    logic [W-1:0] qs [$];
    logic [W-1:0] qh [$];
    logic         qi [$];
    logic [97:0]  got, expv;
    int lat, oc;
    run_op(4'd14, $urandom, $urandom_range(1, 1000), lat, oc);
    tests++;
    if (lat !== 32) begin fails++; $display("FAIL b2b_divu_latency got %0d exp 32", lat); end
    a = $urandom; b = $urandom;
    bus.inicio = 1'b1; bus.operacao = 4'd0; bus.dado1 = a; bus.dado2 = b;
    @(posedge clock); #1;
    bus.inicio = 1'b0;
    @(negedge clock);
    got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 31'd0, bus.pronto};
    expv = {a + b, 32'h0, 1'b0, 1'b0, 31'd0, 1'b1};
    tests++;
    if (got !== expv) begin fails++; $display("FAIL b2b_add_after_divu got %h exp %h", got, expv); end
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        got  = {bus.saida, bus.saida_alta, bus.igual, bus.div_zero, 31'd0, bus.pronto};
        expv = {qs.pop_front(), qh.pop_front(), qi.pop_front(), 1'b0, 31'd0, 1'b1};
        tests++;
        if (got !== expv) begin fails++; $display("FAIL b2b_stream idx=%0d got %h exp %h", i, got, expv); end
      end
      if (i < 10) begin
        op = op_simples(); a = $urandom; b = $urandom;
        modelo(op, a, b, s, h, ig, dz);
        qs.push_back(s); qh.push_back(h); qi.push_back(ig);
        bus.inicio = 1'b1; bus.operacao = op; bus.dado1 = a; bus.dado2 = b;
      end else begin
        bus.inicio = 1'b0;
      end
      @(negedge clock);
    end
    tests++;
    if (bus.pronto !== 1'b0) begin fails++; $display("FAIL b2b_stream_end pronto got %b exp 0", bus.pronto); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shifts();
    test_mulu();
    test_busy_ignore();
    test_divu();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
